// File: rtl/uart_io_pkg.sv
// uart_io_pkg
//   Shared definitions for the IO-port UART bridge: port IDs, STATUS bit
//   positions, TX/RX FSM state encodings and the baud divider helper.
package uart_io_pkg;

    localparam logic [7:0] PORT_RX_DATA  = 8'h01;
    localparam logic [7:0] PORT_RX_AVAIL = 8'h02;
    localparam logic [7:0] PORT_TX_FULL  = 8'h03;
    localparam logic [7:0] PORT_STATUS   = 8'h04;

    // STATUS = {2'b0, tx_busy, frm_err, tx_drop, rx_ovr, tx_full, rx_present}
    localparam int ST_RX_PRESENT = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_OVR     = 2;
    localparam int ST_TX_DROP    = 3;
    localparam int ST_FRM_ERR    = 4;
    localparam int ST_TX_BUSY    = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Clocks per 16x oversampling tick, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * 16);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo
//   Single-clock FIFO with combinational head.
//   clk/rst    : clock, async active-high reset (pointers only)
//   push/wdata : write request; accepted when not full, or full with a pop
//   pop        : removes head; ignored when empty
//   rdata      : current head entry
//   full/empty : occupancy flags
import uart_io_pkg::*;

module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit separates full from empty when indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop & ~empty;
        // Full plus same-cycle pop still has room for the new entry.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_io_port.sv
// uart_io_port
//   IO-port bus responder bridging port IDs 0x01..0x04 to an 8N1 UART.
//   clk100/reset      : system clock, async active-high reset
//   IO_port_ID        : port address for the current access
//   IO_write_data     : write data, qualified by IO_write_strobe
//   IO_write_strobe   : one access per high cycle
//   IO_read_strobe    : one access per high cycle (pops RX on port 0x01)
//   IO_read_data      : combinational read data for IO_port_ID
//   uart_rx / uart_tx : serial pins (uart_rx asynchronous, uart_tx idles high)
import uart_io_pkg::*;

module uart_io_port #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    // ---------------- bus decode ----------------
    logic tx_wr, rx_rd, st_w1c;
    assign tx_wr  = IO_write_strobe && (IO_port_ID == PORT_RX_DATA);
    assign rx_rd  = IO_read_strobe  && (IO_port_ID == PORT_RX_DATA);
    assign st_w1c = IO_write_strobe && (IO_port_ID == PORT_STATUS);

    // ---------------- FIFOs ----------------
    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic [7:0] rx_shift_q, rx_shift_d;

    io_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk100), .rst(reset), .push(tx_wr), .pop(tx_pop),
        .wdata(IO_write_data), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    io_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk100), .rst(reset), .push(rx_push), .pop(rx_rd),
        .wdata(rx_shift_q), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- tick generator ----------------
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    always_comb begin
        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // ---------------- TX FSM ----------------
    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_line_q, tx_line_d;
    logic       tx_bit_end, tx_busy;

    assign tx_bit_end = tick && (tx_tick_q == 4'd15);
    assign tx_busy    = (tx_state_q != TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tick) tx_tick_d = tx_tick_q + 4'd1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_tick_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end
            TX_STOP: if (tx_bit_end) begin
                // Chain straight into the next frame so there is no idle gap.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Registered line level lags the state by one clock, keeping uart_tx glitch-free.
    always_comb begin
        case (tx_state_q)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_q[tx_bit_q];
            default:  tx_line_d = 1'b1;
        endcase
    end

    assign uart_tx = tx_line_q;

    // ---------------- RX FSM ----------------
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic       rx_s1_q, rx_s2_q, rx_s3_q;
    logic       rx_fall, rx_bit_end, stop_ok, frm_set, ovr_set;

    assign rx_fall    = rx_s3_q & ~rx_s2_q;
    assign rx_bit_end = tick && (rx_tick_q == 4'd15);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        stop_ok    = 1'b0;
        frm_set    = 1'b0;
        if (tick) rx_tick_d = rx_tick_q + 4'd1;
        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            // Mid-start re-check; restarting the count here puts every later
            // sample 16 ticks apart at bit centres.
            RX_START: if (tick && rx_tick_q == 4'd7) begin
                rx_tick_d = '0;
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: if (rx_bit_end) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
            RX_STOP: if (rx_bit_end) begin
                rx_state_d = RX_IDLE;
                if (rx_s2_q) stop_ok = 1'b1;
                else         frm_set = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        // A same-cycle pop frees a slot in a full FIFO.
        ovr_set = stop_ok & rx_full & ~rx_rd;
        rx_push = stop_ok;
    end

    // ---------------- sticky status ----------------
    logic tx_drop_q, tx_drop_d, rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d;
    logic tx_drop_set;

    // A push that coincides with a TX pop is accepted by the FIFO, not dropped.
    assign tx_drop_set = tx_wr & tx_full & ~tx_pop;

    // Set has priority over write-1-to-clear.
    always_comb begin
        tx_drop_d = tx_drop_set | (tx_drop_q & ~(st_w1c & IO_write_data[ST_TX_DROP]));
        rx_ovr_d  = ovr_set     | (rx_ovr_q  & ~(st_w1c & IO_write_data[ST_RX_OVR]));
        frm_err_d = frm_set     | (frm_err_q & ~(st_w1c & IO_write_data[ST_FRM_ERR]));
    end

    // ---------------- read mux ----------------
    always_comb begin
        case (IO_port_ID)
            PORT_RX_DATA:  IO_read_data = rx_empty ? 8'h00 : rx_head;
            PORT_RX_AVAIL: IO_read_data = rx_empty ? 8'h00 : 8'hFF;
            PORT_TX_FULL:  IO_read_data = tx_full  ? 8'hFF : 8'h00;
            PORT_STATUS:   IO_read_data = {2'b00, tx_busy, frm_err_q, tx_drop_q,
                                           rx_ovr_q, tx_full, ~rx_empty};
            default:       IO_read_data = 8'hFF;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            tx_drop_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            tx_drop_q  <= tx_drop_d;
            rx_ovr_q   <= rx_ovr_d;
            frm_err_q  <= frm_err_d;
        end
    end

endmodule
